// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, MMIO word offsets
// and status register bit positions.
package dmem_pkg;

  typedef enum logic [1:0] {
    STRB_BYTE = 2'b00,
    STRB_HALF = 2'b01,
    STRB_WORD = 2'b10,
    STRB_RSVD = 2'b11
  } strb_e;

  localparam logic [4:0] OFF_CYC_LO = 5'h00;
  localparam logic [4:0] OFF_CYC_HI = 5'h04;
  localparam logic [4:0] OFF_GPIO   = 5'h08;
  localparam logic [4:0] OFF_TOHOST = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;

  localparam int unsigned ST_HALT     = 0;
  localparam int unsigned ST_MISALIGN = 1;
  localparam int unsigned ST_RANGE    = 2;

  // Word slot inside the 32-byte MMIO window.
  function automatic logic [2:0] off_idx(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/dmem_mmio_regs.sv
// MMIO register block: free-running cycle counter, GPIO, tohost/halt and sticky status.
// DMEM_MISALIGN_CHECK_EN enables the err_misalign flag; otherwise it is tied low.
module dmem_mmio_regs
  import dmem_pkg::*;
#(
  parameter logic [31:0] RESET_GPIO = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  wr_idx,
  input  strb_e       size,
  input  logic [31:0] wdata,
  input  logic        set_misalign,
  input  logic        set_range,
  input  logic [2:0]  rd_idx,
  output logic [31:0] rdata,
  output logic [31:0] gpio_out,
  output logic        halt,
  output logic [31:0] tohost,
  output logic        err_misalign,
  output logic        err_range
);

  logic [63:0] cyc;
  logic        wr_status;
  logic        wr_rsvd;

  assign wr_status = we && (wr_idx == off_idx(OFF_STATUS));
  assign wr_rsvd   = we && (wr_idx >  off_idx(OFF_STATUS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc       <= '0;
      gpio_out  <= RESET_GPIO;
      tohost    <= '0;
      halt      <= 1'b0;
      err_range <= 1'b0;
    end else begin
      if (!halt) cyc <= cyc + 64'd1;
      if (we && wr_idx == off_idx(OFF_GPIO) && size == STRB_WORD) gpio_out <= wdata;
      if (we && wr_idx == off_idx(OFF_TOHOST)) begin
        tohost <= wdata;
        halt   <= 1'b1;
      end
      // Set wins over a same-cycle W1C.
      err_range <= (err_range & ~(wr_status & wdata[ST_RANGE])) | set_range | wr_rsvd;
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_misalign <= 1'b0;
    else      err_misalign <= (err_misalign & ~(wr_status & wdata[ST_MISALIGN])) | set_misalign;
  end
`else
  logic unused_misalign;
  assign unused_misalign = set_misalign;
  assign err_misalign    = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (rd_idx)
      off_idx(OFF_CYC_LO): rdata = cyc[31:0];
      off_idx(OFF_CYC_HI): rdata = cyc[63:32];
      off_idx(OFF_GPIO):   rdata = gpio_out;
      off_idx(OFF_STATUS): begin
        rdata[ST_HALT]     = halt;
        rdata[ST_MISALIGN] = err_misalign;
        rdata[ST_RANGE]    = err_range;
      end
      default:             rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: address decode, store lane steering and word-organised RAM.
// DMEM_MISALIGN_CHECK_EN suppresses misaligned half/word stores instead of force-aligning them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter logic [31:0] RESET_GPIO  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address_in,
  input  logic [31:0] mem_data_in,
  input  logic        mem_we,
  input  logic [1:0]  mem_Write_Strobe_in,
  output logic [31:0] mem_data_out,
  output logic [31:0] gpio_out,
  output logic        halt,
  output logic [31:0] tohost,
  output logic        err_misalign,
  output logic        err_range
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] ridx;
  logic          ram_hit;
  logic          mmio_hit;
  strb_e         size;
  logic          store;
  logic          misalign;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          ram_we;
  logic          mmio_we;
  logic          set_range;
  logic          set_misalign;
  logic [31:0]   mmio_rdata;

  assign ridx     = mem_address_in[AW+1:2];
  assign ram_hit  = {1'b0, mem_address_in} < RAM_BYTES;
  assign mmio_hit = !ram_hit && (mem_address_in[31:5] == MMIO_BASE[31:5]);
  assign size     = strb_e'(mem_Write_Strobe_in);
  assign store    = mem_we && !halt && (size != STRB_RSVD);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((size == STRB_HALF) && mem_address_in[0]) ||
                    ((size == STRB_WORD) && (mem_address_in[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Data is replicated across lanes so the byte enables alone pick the placement.
  always_comb begin
    be    = '0;
    wdata = mem_data_in;
    case (size)
      STRB_BYTE: begin
        be[mem_address_in[1:0]] = 1'b1;
        wdata = {4{mem_data_in[7:0]}};
      end
      STRB_HALF: begin
        be[{mem_address_in[1], 1'b0}] = 1'b1;
        be[{mem_address_in[1], 1'b1}] = 1'b1;
        wdata = {2{mem_data_in[15:0]}};
      end
      STRB_WORD: be = '1;
      default:   be = '0;
    endcase
  end

  // rst gates the write so a store coinciding with reset assertion is dropped.
  assign ram_we       = store && ram_hit && !misalign && rst;
  assign mmio_we      = store && mmio_hit && !misalign;
  assign set_range    = store && !ram_hit && !mmio_hit;
  assign set_misalign = store && misalign;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (be[l]) ram[ridx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  dmem_mmio_regs #(
    .RESET_GPIO (RESET_GPIO)
  ) u_mmio (
    .clk          (clk),
    .rst          (rst),
    .we           (mmio_we),
    .wr_idx       (mem_address_in[4:2]),
    .size         (size),
    .wdata        (mem_data_in),
    .set_misalign (set_misalign),
    .set_range    (set_range),
    .rd_idx       (mem_address_in[4:2]),
    .rdata        (mmio_rdata),
    .gpio_out     (gpio_out),
    .halt         (halt),
    .tohost       (tohost),
    .err_misalign (err_misalign),
    .err_range    (err_range)
  );

  always_comb begin
    mem_data_out = '0;
    if (ram_hit)       mem_data_out = ram[ridx];
    else if (mmio_hit) mem_data_out = mmio_rdata;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side responder for the pipelined core's memory port. Serves loads and stores issued from the core's MEM stage.
- Decodes each address into one of two targets:
  - on-chip word-organised data RAM;
  - small MMIO block: cycle counter, GPIO output, tohost/halt register, sticky error status.
- Read data is returned in the same cycle. The core's load unit does byte/half extraction from the full aligned word.

Parameters:
- DEPTH_WORDS, 1024: data RAM depth in 32-bit words. Must be a power of 2.
- MMIO_BASE, 32'h8000_0000: base address of the MMIO window, 32 bytes, word registers.
- RESET_GPIO, 32'h0000_0000: reset value of the GPIO output register.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- mem_address_in  in  32  byte address from the core MEM stage
- mem_data_in  in  32  store data from the core, right-aligned (byte in [7:0], half in [15:0])
- mem_we  in  1  store enable for this cycle
- mem_Write_Strobe_in  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- mem_data_out  out  32  aligned read word to the core (combinational)
- gpio_out  out  32  GPIO output register
- halt  out  1  sticky, set by a tohost write
- tohost  out  32  value of the last tohost write
- err_misalign  out  1  sticky misaligned-store flag
- err_range  out  1  sticky unmapped-store flag

Behaviour:
- Reset: gpio_out=RESET_GPIO; halt, tohost, err_misalign, err_range and the 64-bit cycle counter all 0. RAM contents are not reset.
- Address decode:
  - RAM hit when mem_address_in < DEPTH_WORDS*4. Word index = address[log2(DEPTH_WORDS)+1:2].
  - MMIO hit when address[31:5]==MMIO_BASE[31:5].
  - Anything else is unmapped.
- Reads (no read enable; decode is evaluated every cycle):
  - mem_data_out is a combinational function of the address and current state.
  - RAM hit returns the full aligned word.
  - Unmapped reads and reserved MMIO offsets return 0.
  - A store followed by a load to the same word on the next cycle returns the new data. Within the same cycle, the read shows the pre-write data.
- Stores commit on the rising edge when mem_we=1 and halt=0. Lane placement:
  - byte: lane = address[1:0], data = mem_data_in[7:0];
  - half: lanes {address[1],0} and {address[1],1}, data = mem_data_in[15:0];
  - word: all 4 lanes.
  - Strobe 11: no write, no error.
  - Unmapped store: no write, err_range<=1.
- MMIO offsets:
  - 0x00 cyc_lo (RO)
  - 0x04 cyc_hi (RO)
  - 0x08 gpio (RW, word stores only; byte/half stores ignored)
  - 0x0C tohost (WO; a store sets tohost<=data and halt<=1; reads 0)
  - 0x10 status (RO bits: [0] halt, [1] err_misalign, [2] err_range; W1C on bits [2:1])
  - 0x14–0x1C reserved. Stores there set err_range.
- Writes to RO offsets 0x00/0x04 are ignored silently.
- Cycle counter: increments by 1 every cycle after reset while halt=0 and freezes once halt=1. cyc_hi/cyc_lo are read live, with no snapshot. Wraps from 2^64-1 to 0.
- After halt=1, all stores are ignored (RAM, GPIO, W1C included) until reset; reads continue to work.
- Simultaneous events: a W1C and a new error in the same cycle leaves the flag set.
- Reset asserted mid-store: the store is lost, and registers take their reset values immediately.

Optional Feature:
- DMEM_MISALIGN_CHECK_EN defined:
  - a half store with address[0]=1, or a word store with address[1:0]!=0, is suppressed and sets err_misalign;
  - misaligned MMIO stores are also suppressed.
- Undefined:
  - alignment is forced: half uses address[1] only, word ignores address[1:0];
  - no error is raised, and err_misalign is tied 0 (status[1] reads 0).

Decomposition:
- Package dmem_pkg holds:
  - strobe encodings (STRB_BYTE=2'b00, STRB_HALF=2'b01, STRB_WORD=2'b10);
  - MMIO offsets (OFF_CYC_LO … OFF_STATUS);
  - status bit indices.
- One sub-module, dmem_mmio_regs, holds the counter, GPIO, tohost/halt and status register. The top holds decode, lane steering and RAM.

Test Plan:
- Word store 32'hDEADBEEF to 0x10, then byte store 8'h55 to 0x12 -> read of 0x10 returns 32'hDE55BEEF on the cycle after the second store.
- Half store 16'hA5A5 to 0x16 -> word 0x14 upper half = A5A5, lower half unchanged. Same-cycle read of 0x14 shows the old value.
- Read MMIO_BASE+0x00 at two points 10 cycles apart -> difference is exactly 10.
- Store 32'h1 to MMIO_BASE+0x0C -> tohost=1 and halt=1 next cycle; counter frozen. A later store of 32'h77 to RAM 0x0 leaves the word unchanged.
- Store to 0x4000_0000 -> err_range=1 and status reads 32'h4. Store 32'h4 to status -> err_range=0.
- Word store to 0x22 -> with DMEM_MISALIGN_CHECK_EN: no write, err_misalign=1. Without it: write lands at word 0x20, err_misalign=0.
